div_arbiter: RTL and testbench
==============================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 The block SHALL have parameter M, default 26, giving the dividend and quotient width.
REQ-002 The block SHALL have parameter N, default 14, giving the divisor width.
REQ-003 The block SHALL have parameter LAT, default 26, giving the fixed pipeline latency of mod_divider in clock edges.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester i presents an operation.
REQ-007 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: grant to requester i.
REQ-008 The block SHALL have ports req0_dividend and req1_dividend, input, M bits each: dividend operands.
REQ-009 The block SHALL have ports req0_divisor and req1_divisor, input, N bits each: divisor operands.
REQ-010 The block SHALL have ports rsp0_valid and rsp1_valid, output, 1 bit each: one-cycle result strobe to requester i.
REQ-011 The block SHALL have ports rsp0_quotient and rsp1_quotient, output, M bits each: result for requester i.
REQ-012 The block SHALL have ports rsp0_dz and rsp1_dz, output, 1 bit each: divide-by-zero flag qualified by rspi_valid.
REQ-013 The block SHALL have port div_dividend, output, M bits: registered dividend to mod_divider.
REQ-014 The block SHALL have port div_divisor, output, N bits: registered divisor to mod_divider.
REQ-015 The block SHALL have port div_merchant, input, M bits: quotient from mod_divider.
REQ-016 The block SHALL have port in_flight, output, clog2(LAT+2) bits: count of accepted operations without a delivered response.

Function
REQ-017 A transfer SHALL occur on requester i at a rising edge where reqi_valid and reqi_ready are both 1.
REQ-018 At most one reqi_ready SHALL be 1 in any cycle; ready SHALL be combinational from the valids and the priority pointer.
REQ-019 With exactly one requester valid, that requester SHALL be granted regardless of the pointer.
REQ-020 With both requesters valid, the requester not granted most recently SHALL be granted (round-robin).
REQ-021 The priority pointer SHALL record the id of the last transfer and update only on a transfer.
REQ-022 Throughput SHALL be one transfer per cycle; no response backpressure exists.
REQ-023 On a transfer, div_dividend and div_divisor SHALL load the granted operands; with no transfer they SHALL hold their value.
REQ-024 A tag shift register, LAT+1 stages deep, SHALL carry {valid, id, dz} for each transfer, with dz = (divisor == 0).
REQ-025 rspi_valid SHALL pulse high for exactly one cycle, starting LAT+1 rising edges after the transfer edge, for the tag's id only.
REQ-026 The rspi_quotient register SHALL capture div_merchant at the same edge, or all ones (2^M-1) when the tag dz is 1.
REQ-027 rspi_quotient SHALL hold its value when rspi_valid is 0.
REQ-028 Responses SHALL be delivered in transfer order.
REQ-029 in_flight SHALL increment on a transfer and decrement on a response; if both occur at the same edge, in_flight SHALL stay unchanged.
REQ-030 in_flight SHALL never exceed LAT+1.

Reset
REQ-031 While rst is 1: req*_ready, rsp*_valid, rsp*_dz, in_flight, all tag valids SHALL be 0.
REQ-032 While rst is 1: rsp*_quotient, div_dividend, div_divisor SHALL be 0.
REQ-033 While rst is 1: the pointer SHALL be 1, so req0 wins the first tie.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operations, and no rsp*_valid SHALL follow for them after release.

Verification
REQ-035 Bench scenario, single operation: req0 with dividend 0x1FFC000 and divisor 0x0001, single transfer at edge E -> rsp0_valid high for one cycle after edge E+27, rsp0_quotient = 0x1FFC000, rsp0_dz = 0, rsp1_valid = 0.
REQ-036 Bench scenario, contention: both requesters valid for 4 cycles after reset -> grant order 0,1,0,1; responses arrive on consecutive cycles with matching ids and quotients.
REQ-037 Bench scenario, divide by zero: req1 with divisor 0 -> rsp1_valid after LAT+1 edges, rsp1_dz = 1, rsp1_quotient = 0x3FFFFFF.
REQ-038 Bench scenario, full pipeline: req0 valid continuously for 40 cycles -> in_flight saturates at 27 and stays there; 40 responses arrive in order.
REQ-039 Bench scenario, reset mid-operation: rst pulsed 10 cycles after 5 transfers -> in_flight = 0 and no rsp*_valid in the following 40 cycles.
REQ-040 Bench scenario, idle hold: no requests for 20 cycles -> div_dividend and div_divisor unchanged, both ready low.

Source files
------------

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a fixed-latency divider.
// Operands are registered to the divider and responses are steered back by a tag pipeline.

module div_rsp_lane #(
  parameter int M  = 26,
  parameter int ID = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tag_vld,
  input  logic         tag_id,
  input  logic         tag_dz,
  input  logic [M-1:0] merchant,
  output logic         rsp_valid,
  output logic [M-1:0] rsp_quotient,
  output logic         rsp_dz
);
  logic hit;
  assign hit = tag_vld && (tag_id == 1'(ID));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_quotient <= '0;
      rsp_dz       <= 1'b0;
    end else begin
      rsp_valid <= hit;
      rsp_dz    <= hit & tag_dz;
      if (hit) rsp_quotient <= tag_dz ? '1 : merchant;
    end
  end
endmodule

module div_arbiter #(
  parameter int M   = 26,
  parameter int N   = 14,
  parameter int LAT = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic                      req1_valid,
  output logic                      req0_ready,
  output logic                      req1_ready,
  input  logic [M-1:0]              req0_dividend,
  input  logic [M-1:0]              req1_dividend,
  input  logic [N-1:0]              req0_divisor,
  input  logic [N-1:0]              req1_divisor,
  output logic                      rsp0_valid,
  output logic                      rsp1_valid,
  output logic [M-1:0]              rsp0_quotient,
  output logic [M-1:0]              rsp1_quotient,
  output logic                      rsp0_dz,
  output logic                      rsp1_dz,
  output logic [M-1:0]              div_dividend,
  output logic [N-1:0]              div_divisor,
  input  logic [M-1:0]              div_merchant,
  output logic [$clog2(LAT+2)-1:0]  in_flight
);
  localparam int CW = $clog2(LAT+2);

  logic [1:0]        req_valid, grant;
  logic [1:0]        rsp_valid, rsp_dz;
  logic [1:0][M-1:0] rsp_quotient;
  logic              ptr, xfer, xfer_id;
  logic [M-1:0]      sel_dividend;
  logic [N-1:0]      sel_divisor;
  logic [LAT:0]      vld_pipe, id_pipe, dz_pipe;

  assign req_valid = {req1_valid, req0_valid};

  // ptr holds the last granted id; on a tie the other requester wins.
  always_comb begin
    grant = '0;
    if (!rst) grant = (&req_valid) ? (ptr ? 2'b01 : 2'b10) : req_valid;
  end

  assign req0_ready   = grant[0];
  assign req1_ready   = grant[1];
  assign xfer         = |grant;
  assign xfer_id      = grant[1];
  assign sel_dividend = xfer_id ? req1_dividend : req0_dividend;
  assign sel_divisor  = xfer_id ? req1_divisor  : req0_divisor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr          <= 1'b1;
      div_dividend <= '0;
      div_divisor  <= '0;
      vld_pipe     <= '0;
      id_pipe      <= '0;
      dz_pipe      <= '0;
      in_flight    <= '0;
    end else begin
      if (xfer) begin
        ptr          <= xfer_id;
        div_dividend <= sel_dividend;
        div_divisor  <= sel_divisor;
      end
      vld_pipe <= {vld_pipe[LAT-1:0], xfer};
      id_pipe  <= {id_pipe[LAT-1:0], xfer_id};
      dz_pipe  <= {dz_pipe[LAT-1:0], sel_divisor == '0};
      // Oldest tag retires on the same edge its response is registered.
      case ({xfer, vld_pipe[LAT]})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_lane
    div_rsp_lane #(.M(M), .ID(g)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .tag_vld      (vld_pipe[LAT]),
      .tag_id       (id_pipe[LAT]),
      .tag_dz       (dz_pipe[LAT]),
      .merchant     (div_merchant),
      .rsp_valid    (rsp_valid[g]),
      .rsp_quotient (rsp_quotient[g]),
      .rsp_dz       (rsp_dz[g])
    );
  end

  assign rsp0_valid    = rsp_valid[0];
  assign rsp1_valid    = rsp_valid[1];
  assign rsp0_quotient = rsp_quotient[0];
  assign rsp1_quotient = rsp_quotient[1];
  assign rsp0_dz       = rsp_dz[0];
  assign rsp1_dz       = rsp_dz[1];
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural LAT-deep divider model.

module tb_div_arbiter;
  localparam int M   = 26;
  localparam int N   = 14;
  localparam int LAT = 26;
  localparam int CW  = $clog2(LAT+2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [M-1:0]  req0_dividend = '0, req1_dividend = '0;
  logic [N-1:0]  req0_divisor = '0, req1_divisor = '0;
  logic          rsp0_valid, rsp1_valid, rsp0_dz, rsp1_dz;
  logic [M-1:0]  rsp0_quotient, rsp1_quotient;
  logic [M-1:0]  div_dividend, div_merchant;
  logic [N-1:0]  div_divisor;
  logic [CW-1:0] in_flight;

  div_arbiter #(.M(M), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_dividend(req0_dividend), .req1_dividend(req1_dividend),
    .req0_divisor(req0_divisor), .req1_divisor(req1_divisor),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_quotient(rsp0_quotient), .rsp1_quotient(rsp1_quotient),
    .rsp0_dz(rsp0_dz), .rsp1_dz(rsp1_dz),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_merchant(div_merchant), .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: result of the registered operands appears LAT edges later.
  logic [M-1:0] mpipe [LAT];
  initial for (int k = 0; k < LAT; k++) mpipe[k] = '0;
  always @(posedge clk) begin
    mpipe[0] <= (div_divisor == '0) ? '0 : div_dividend / {{(M-N){1'b0}}, div_divisor};
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign div_merchant = mpipe[LAT-1];

  int           r_id[$], r_cyc[$];
  logic [M-1:0] r_q[$];
  logic         r_dz[$];
  always @(negedge clk) begin
    if (rsp0_valid) begin r_id.push_back(0); r_cyc.push_back(cyc); r_q.push_back(rsp0_quotient); r_dz.push_back(rsp0_dz); end
    if (rsp1_valid) begin r_id.push_back(1); r_cyc.push_back(cyc); r_q.push_back(rsp1_quotient); r_dz.push_back(rsp1_dz); end
  end

  int errors = 0;
  int checks = 0;

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_dividend = '0; req1_dividend = '0;
    req0_divisor = '0;  req1_divisor = '0;
  endtask

  task automatic clear_q();
    r_id.delete(); r_cyc.delete(); r_q.delete(); r_dz.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
    @(negedge clk);
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_dz, rsp1_dz} !== 4'b0) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 0000", {rsp0_valid, rsp1_valid, rsp0_dz, rsp1_dz}); end
    checks++;
    if (in_flight !== '0) begin errors++; $display("FAIL reset_in_flight: got %0d expected 0", in_flight); end
    checks++;
    if ({rsp0_quotient, rsp1_quotient, div_dividend, div_divisor} !== '0) begin errors++; $display("FAIL reset_data: got %0h/%0h/%0h/%0h expected 0", rsp0_quotient, rsp1_quotient, div_dividend, div_divisor); end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single();
    int e;
    do_reset();
    req0_valid = 1'b1; req0_dividend = M'(26'h1FFC000); req0_divisor = N'(1);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_grant: got %b expected 01", {req1_ready, req0_ready}); end
    e = cyc + 1;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (in_flight !== CW'(1) || div_dividend !== M'(26'h1FFC000) || div_divisor !== N'(1)) begin
      errors++; $display("FAIL single_issue: got in_flight=%0d dvd=%0h dvs=%0h expected 1/1ffc000/1", in_flight, div_dividend, div_divisor);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (r_id.size() != 1) begin errors++; $display("FAIL single_rsp_count: got %0d expected 1", r_id.size()); end
    else begin
      checks++;
      if (r_id[0] != 0 || r_cyc[0] != e + 27 || r_q[0] !== M'(26'h1FFC000) || r_dz[0] !== 1'b0) begin
        errors++; $display("FAIL single_rsp: got id=%0d cyc=%0d q=%0h dz=%b expected 0/%0d/1ffc000/0", r_id[0], r_cyc[0], r_q[0], r_dz[0], e + 27);
      end
    end
    checks++;
    if (rsp0_quotient !== M'(26'h1FFC000) || in_flight !== '0) begin errors++; $display("FAIL single_hold: got q=%0h in_flight=%0d expected 1ffc000/0", rsp0_quotient, in_flight); end
  endtask

  task automatic test_contention();
    int e = 0, i0 = 0, i1 = 0, g;
    int a0[2] = '{100, 250};
    int b0[2] = '{3, 5};
    int a1[2] = '{1000, 999};
    int b1[2] = '{7, 9};
    int exp_g[4] = '{0, 1, 0, 1};
    int exp_q[4] = '{33, 142, 50, 111};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1'b1; req0_dividend = M'(a0[i0]); req0_divisor = N'(b0[i0]);
      req1_valid = 1'b1; req1_dividend = M'(a1[i1]); req1_divisor = N'(b1[i1]);
      #1;
      g = req1_ready ? 1 : 0;
      checks++;
      if ((req0_ready ^ req1_ready) !== 1'b1 || g != exp_g[k]) begin
        errors++; $display("FAIL contention_grant%0d: got ready=%b%b expected id %0d", k, req1_ready, req0_ready, exp_g[k]);
      end
      if (k == 0) e = cyc + 1;
      if (g == 0) begin if (i0 < 1) i0++; end
      else        begin if (i1 < 1) i1++; end
      @(negedge clk);
    end
    idle_inputs();
    repeat (35) @(negedge clk);
    checks++;
    if (r_id.size() != 4) begin errors++; $display("FAIL contention_rsp_count: got %0d expected 4", r_id.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (r_id[k] != exp_g[k] || r_q[k] !== M'(exp_q[k]) || r_cyc[k] != e + 27 + k || r_dz[k] !== 1'b0) begin
          errors++; $display("FAIL contention_rsp%0d: got id=%0d q=%0d cyc=%0d expected %0d/%0d/%0d", k, r_id[k], r_q[k], r_cyc[k], exp_g[k], exp_q[k], e + 27 + k);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    int e;
    do_reset();
    req1_valid = 1'b1; req1_dividend = M'(12345); req1_divisor = '0;
    e = cyc + 1;
    @(negedge clk);
    idle_inputs();
    repeat (35) @(negedge clk);
    checks++;
    if (r_id.size() != 1) begin errors++; $display("FAIL dz_rsp_count: got %0d expected 1", r_id.size()); end
    else begin
      checks++;
      if (r_id[0] != 1 || r_cyc[0] != e + 27 || r_q[0] !== M'(26'h3FFFFFF) || r_dz[0] !== 1'b1) begin
        errors++; $display("FAIL dz_rsp: got id=%0d cyc=%0d q=%0h dz=%b expected 1/%0d/3ffffff/1", r_id[0], r_cyc[0], r_q[0], r_dz[0], e + 27);
      end
    end
  endtask

  task automatic test_full_pipeline();
    int e = 0, maxf = 0;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      if (k < 40) begin
        req0_valid = 1'b1; req0_dividend = M'(3 * k + 7); req0_divisor = N'(3);
      end else idle_inputs();
      if (k == 0) e = cyc + 1;
      @(negedge clk);
      if (int'(in_flight) > maxf) maxf = int'(in_flight);
      if (k == 26 || k == 39) begin
        checks++;
        if (in_flight !== CW'(27)) begin errors++; $display("FAIL full_in_flight_k%0d: got %0d expected 27", k, in_flight); end
      end
    end
    checks++;
    if (maxf != 27 || in_flight !== '0) begin errors++; $display("FAIL full_saturation: got max=%0d end=%0d expected 27/0", maxf, in_flight); end
    checks++;
    if (r_id.size() != 40) begin errors++; $display("FAIL full_rsp_count: got %0d expected 40", r_id.size()); end
    else begin
      for (int k = 0; k < 40; k++) begin
        checks++;
        if (r_id[k] != 0 || r_q[k] !== M'(k + 2) || r_cyc[k] != e + 27 + k) begin
          errors++; $display("FAIL full_rsp%0d: got id=%0d q=%0d cyc=%0d expected 0/%0d/%0d", k, r_id[k], r_q[k], r_cyc[k], k + 2, e + 27 + k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      req0_valid = 1'b1; req0_dividend = M'(1000 + k); req0_divisor = N'(10);
      @(negedge clk);
    end
    idle_inputs();
    repeat (10) @(negedge clk);
    checks++;
    if (in_flight !== CW'(5)) begin errors++; $display("FAIL mid_in_flight_before: got %0d expected 5", in_flight); end
    rst = 1'b1;
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 00", {req1_ready, req0_ready}); end
    @(negedge clk);
    checks++;
    if (in_flight !== '0 || div_dividend !== '0 || {rsp0_valid, rsp1_valid} !== 2'b00) begin
      errors++; $display("FAIL mid_in_reset: got in_flight=%0d dvd=%0h rsp=%b%b expected 0/0/00", in_flight, div_dividend, rsp1_valid, rsp0_valid);
    end
    rst = 1'b0;
    idle_inputs();
    clear_q();
    repeat (40) @(negedge clk);
    checks++;
    if (r_id.size() != 0 || in_flight !== '0) begin errors++; $display("FAIL mid_after_release: got rsps=%0d in_flight=%0d expected 0/0", r_id.size(), in_flight); end
  endtask

  task automatic test_idle_hold();
    do_reset();
    req0_valid = 1'b1; req0_dividend = M'(777); req0_divisor = N'(5);
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (div_dividend !== M'(777) || div_divisor !== N'(5) || {req1_ready, req0_ready} !== 2'b00) begin
        errors++; $display("FAIL idle_hold%0d: got dvd=%0d dvs=%0d ready=%b%b expected 777/5/00", k, div_dividend, div_divisor, req1_ready, req0_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_div_zero();
    test_full_pipeline();
    test_reset_mid();
    test_idle_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
